block_lu_scheduler: RTL and testbench

Sequencer for the 2x2 block-LU flow built from the `lu`, `triang_matrix_inv` and complex multiply/add (Schur) engines. On one start request it runs five engine steps in fixed order: LU of A0, inverse of L0, inverse of U0, Schur update of A3, LU of A3. For each step it selects the matrix buffer attached to the engine row ports, issues a start pulse and detects completion. It sits between the top-level command logic and the three engines and replaces hand-sequenced start/wait control.

---
 rtl/block_lu_scheduler.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_block_lu_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_lu_scheduler.sv
// Five-step 2x2 block-LU sequencer: LU(A0), inv(L0), inv(U0), Schur(A3), LU(A3).
// Optional per-step watchdog is compiled in with BLOCK_LU_SCHED_WATCHDOG_EN.
module block_lu_scheduler #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       flush_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [2:0] step_o,
    output logic       step_done_o,
    output logic [1:0] buf_sel_o,
    output logic       lu_start_o,
    output logic       ti_start_o,
    output logic       schur_start_o,
    output logic       lu_flush_o,
    output logic       ti_flush_o,
    output logic       schur_flush_o,
    input  logic       lu_busy_i,
    input  logic       ti_busy_i,
    input  logic       schur_busy_i,
    input  logic       lu_in_ready_i,
    input  logic       ti_in_ready_i,
    input  logic       schur_in_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [1:0] ENG_LU    = 2'd0;
    localparam logic [1:0] ENG_TI    = 2'd1;
    localparam logic [1:0] ENG_SCHUR = 2'd2;
    localparam logic [3:0] CNT_LAST  = 4'(START_CYCLES - 1);
    localparam logic [2:0] LAST_STEP = 3'd4;

    function automatic logic [1:0] eng_of(input logic [2:0] step);
        case (step)
            3'd0:       eng_of = ENG_LU;
            3'd1, 3'd2: eng_of = ENG_TI;
            3'd3:       eng_of = ENG_SCHUR;
            3'd4:       eng_of = ENG_LU;
            default:    eng_of = ENG_LU;
        endcase
    endfunction

    function automatic logic [1:0] buf_of(input logic [2:0] step);
        case (step)
            3'd0:       buf_of = 2'd0;
            3'd1:       buf_of = 2'd1;
            3'd2:       buf_of = 2'd2;
            3'd3, 3'd4: buf_of = 2'd3;
            default:    buf_of = 2'd0;
        endcase
    endfunction

    function automatic logic is_active(input state_t s);
        is_active = (s == S_START) || (s == S_ARM) || (s == S_WAIT);
    endfunction

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [3:0] cnt_q, cnt_d;
    // settle_q marks the strobe-free first START cycle after a step hand-off,
    // giving buf_sel_o a full cycle to settle before the next strobe rises.
    logic       settle_q, settle_d;
    logic       flush_prev_q;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] step_o_q, step_o_d;
    logic       step_done_q, step_done_d;
    logic [1:0] buf_sel_q, buf_sel_d;
    logic       lu_start_q, lu_start_d;
    logic       ti_start_q, ti_start_d;
    logic       schur_start_q, schur_start_d;
    logic       flush_pulse_q, flush_pulse_d;
    logic       sel_busy_s;
    logic       sel_ready_s;
    logic       strobe_on_s;

`ifdef BLOCK_LU_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
    logic            wd_expired_s;
`endif

    // Busy/ready of the engine owning the current step.
    always_comb begin
        sel_busy_s  = 1'b0;
        sel_ready_s = 1'b0;
        case (eng_of(step_q))
            ENG_LU: begin
                sel_busy_s  = lu_busy_i;
                sel_ready_s = lu_in_ready_i;
            end
            ENG_TI: begin
                sel_busy_s  = ti_busy_i;
                sel_ready_s = ti_in_ready_i;
            end
            ENG_SCHUR: begin
                sel_busy_s  = schur_busy_i;
                sel_ready_s = schur_in_ready_i;
            end
            default: begin
                sel_busy_s  = 1'b0;
                sel_ready_s = 1'b0;
            end
        endcase
    end

    // Next-state logic and the values every registered output takes next cycle.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        step_done_d = 1'b0;
`ifdef BLOCK_LU_SCHED_WATCHDOG_EN
        wd_expired_s = is_active(state_q) && (wd_q == WD_W'(TIMEOUT - 1));
`endif

        if (flush_i) begin
            state_d  = S_IDLE;
            step_d   = 3'd0;
            cnt_d    = 4'd0;
            settle_d = 1'b0;
`ifdef BLOCK_LU_SCHED_WATCHDOG_EN
        end else if (wd_expired_s) begin
            state_d  = S_ERROR;
            cnt_d    = 4'd0;
            settle_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state_d  = S_START;
                        step_d   = 3'd0;
                        cnt_d    = 4'd0;
                        settle_d = 1'b0;
                    end else begin
                        state_d  = state_q;
                    end
                end
                S_START: begin
                    if (settle_q) begin
                        settle_d = 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_ARM;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_ARM: begin
                    if (sel_busy_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ARM;
                    end
                end
                S_WAIT: begin
                    if (!sel_busy_s && sel_ready_s) begin
                        step_done_d = 1'b1;
                        if (step_q == LAST_STEP) begin
                            state_d = S_DONE;
                        end else begin
                            state_d  = S_START;
                            step_d   = step_q + 3'd1;
                            cnt_d    = 4'd0;
                            settle_d = 1'b1;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = 3'd0;
                end
            endcase
        end

        strobe_on_s   = (state_d == S_START) && !settle_d;
        busy_d        = is_active(state_d);
        done_d        = (state_d == S_DONE) && (state_q != S_DONE);
        step_o_d      = step_done_d ? step_q : step_d;
        buf_sel_d     = buf_of(step_d);
        lu_start_d    = strobe_on_s && (eng_of(step_d) == ENG_LU);
        ti_start_d    = strobe_on_s && (eng_of(step_d) == ENG_TI);
        schur_start_d = strobe_on_s && (eng_of(step_d) == ENG_SCHUR);
        flush_pulse_d = flush_i && !flush_prev_q;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            step_q        <= 3'd0;
            cnt_q         <= 4'd0;
            settle_q      <= 1'b0;
            flush_prev_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            step_o_q      <= 3'd0;
            step_done_q   <= 1'b0;
            buf_sel_q     <= 2'd0;
            lu_start_q    <= 1'b0;
            ti_start_q    <= 1'b0;
            schur_start_q <= 1'b0;
            flush_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            settle_q      <= settle_d;
            flush_prev_q  <= flush_i;
            busy_q        <= busy_d;
            done_q        <= done_d;
            step_o_q      <= step_o_d;
            step_done_q   <= step_done_d;
            buf_sel_q     <= buf_sel_d;
            lu_start_q    <= lu_start_d;
            ti_start_q    <= ti_start_d;
            schur_start_q <= schur_start_d;
            flush_pulse_q <= flush_pulse_d;
        end
    end

`ifdef BLOCK_LU_SCHED_WATCHDOG_EN
    // Step watchdog restarts on each START entry and runs through ARM and WAIT.
    always_comb begin
        if (flush_i) begin
            wd_d = '0;
        end else if ((state_d == S_START) && (state_q != S_START)) begin
            wd_d = '0;
        end else if (is_active(state_q)) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end
        error_d = (state_d == S_ERROR);
    end

    // Watchdog counter and error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign step_o        = step_o_q;
    assign step_done_o   = step_done_q;
    assign buf_sel_o     = buf_sel_q;
    assign lu_start_o    = lu_start_q;
    assign ti_start_o    = ti_start_q;
    assign schur_start_o = schur_start_q;
    assign lu_flush_o    = flush_pulse_q;
    assign ti_flush_o    = flush_pulse_q;
    assign schur_flush_o = flush_pulse_q;

endmodule

// File: tb/tb_block_lu_scheduler.sv
// Directed bench for block_lu_scheduler with simple busy/ready engine models.
module tb_block_lu_scheduler;

    logic       clk, rst, start_i, flush_i;
    logic       busy_o, done_o, error_o, step_done_o;
    logic [2:0] step_o;
    logic [1:0] buf_sel_o;
    logic       lu_start_o, ti_start_o, schur_start_o;
    logic       lu_flush_o, ti_flush_o, schur_flush_o;
    logic [2:0] e_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] EXP_VEC [5] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b001};
    localparam logic [1:0] EXP_BUF [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

    block_lu_scheduler #(.START_CYCLES(2), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .step_o(step_o),
        .step_done_o(step_done_o), .buf_sel_o(buf_sel_o),
        .lu_start_o(lu_start_o), .ti_start_o(ti_start_o), .schur_start_o(schur_start_o),
        .lu_flush_o(lu_flush_o), .ti_flush_o(ti_flush_o), .schur_flush_o(schur_flush_o),
        .lu_busy_i(e_busy[0]), .ti_busy_i(e_busy[1]), .schur_busy_i(e_busy[2]),
        .lu_in_ready_i(!e_busy[0]), .ti_in_ready_i(!e_busy[1]), .schur_in_ready_i(!e_busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] strobe, flushv;
    assign strobe = {schur_start_o, ti_start_o, lu_start_o};
    assign flushv = {schur_flush_o, ti_flush_o, lu_flush_o};

    // Engine models: mode 0 busy one cycle after strobe falls, 1 busy during first strobe cycle, 2 never busy.
    logic [1:0] mode [3];
    int         e_rem [3];
    logic [2:0] e_pend, e_prev;
    always @(negedge clk) begin
        for (int e = 0; e < 3; e++) begin
            if (rst || flushv[e]) begin
                e_busy[e] = 1'b0; e_pend[e] = 1'b0; e_rem[e] = 0;
            end else begin
                if (e_busy[e]) begin
                    e_rem[e] = e_rem[e] - 1;
                    if (e_rem[e] == 0) e_busy[e] = 1'b0;
                end
                if (e_pend[e]) begin
                    e_pend[e] = 1'b0; e_busy[e] = 1'b1; e_rem[e] = 10;
                end
                if (mode[e] == 2'd1 && strobe[e] && !e_prev[e] && !e_busy[e]) begin
                    e_busy[e] = 1'b1; e_rem[e] = 10;
                end
                if (mode[e] == 2'd0 && !strobe[e] && e_prev[e]) e_pend[e] = 1'b1;
            end
            e_prev[e] = strobe[e];
        end
    end

    // Event log of DUT outputs, sampled mid-cycle.
    int         cyc = 0, n_rise = 0, n_sd = 0, n_done = 0, overlap = 0, err_cyc = 0;
    int         rise_cyc [64], width [64], sd_cyc [64];
    logic [2:0] rise_vec [64], sd_step [64];
    logic [1:0] rise_buf [64], pre_buf [64], sd_buf [64];
    logic [2:0] s_prev = 3'b000;
    logic [1:0] buf_prev = 2'd0;
    logic       err_prev = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (strobe != 3'b000) begin
            if (strobe != s_prev) begin
                rise_cyc[n_rise] = cyc; rise_vec[n_rise] = strobe;
                rise_buf[n_rise] = buf_sel_o; pre_buf[n_rise] = buf_prev;
                width[n_rise] = 1; n_rise = n_rise + 1;
            end else begin
                width[n_rise-1] = width[n_rise-1] + 1;
            end
        end
        if (!$onehot0(strobe)) overlap = overlap + 1;
        if (step_done_o) begin
            sd_cyc[n_sd] = cyc; sd_step[n_sd] = step_o; sd_buf[n_sd] = buf_sel_o; n_sd = n_sd + 1;
        end
        if (done_o) n_done = n_done + 1;
        if (error_o && !err_prev) err_cyc = cyc;
        s_prev = strobe; buf_prev = buf_sel_o; err_prev = error_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin @(posedge clk); k++; end
        chk("wait_done", 32'(n_done >= target), 32'd1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int k = 0;
        while (n_rise < target && k < budget) begin @(posedge clk); k++; end
        chk("wait_rises", 32'(n_rise >= target), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1;
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_lu_strobe", 32'(strobe), 32'b001);
        chk("start_step", 32'(step_o), 32'd0);
        chk("start_buf", 32'(buf_sel_o), 32'd0);
        chk("start_err_clr", 32'(error_o), 32'd0);
        start_i = 1'b0;
    endtask

    initial begin
        int b_r, b_s, b_d, k;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        mode[0] = 2'd0; mode[1] = 2'd0; mode[2] = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'({busy_o, done_o, error_o, step_o, step_done_o, buf_sel_o,
                               strobe, flushv}), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        // Nominal five-step run
        b_r = n_rise; b_s = n_sd; b_d = n_done;
        pulse_start();
        wait_done(b_d + 1, 400);
        @(posedge clk); #1;
        chk("nom_busy_after", 32'(busy_o), 32'd0);
        chk("nom_step_hold", 32'(step_o), 32'd4);
        chk("nom_buf_hold", 32'(buf_sel_o), 32'd3);
        chk("nom_done_count", 32'(n_done - b_d), 32'd1);
        chk("nom_rise_count", 32'(n_rise - b_r), 32'd5);
        chk("nom_sd_count", 32'(n_sd - b_s), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("nom_eng%0d", i), 32'(rise_vec[b_r+i]), 32'(EXP_VEC[i]));
            chk($sformatf("nom_width%0d", i), 32'(width[b_r+i]), 32'd2);
            chk($sformatf("nom_buf%0d", i), 32'(rise_buf[b_r+i]), 32'(EXP_BUF[i]));
            chk($sformatf("nom_prebuf%0d", i), 32'(pre_buf[b_r+i]), 32'(EXP_BUF[i]));
            chk($sformatf("nom_sdstep%0d", i), 32'(sd_step[b_s+i]), 32'(i));
        end
        chk("nom_sd0_buf_next", 32'(sd_buf[b_s]), 32'd1);
        chk("nom_latency0", 32'(sd_cyc[b_s] - rise_cyc[b_r]), 32'd14);
        chk("nom_next_rise", 32'(rise_cyc[b_r+1] - sd_cyc[b_s]), 32'd1);
        chk("nom_overlap", 32'(overlap), 32'd0);

        // Flush during step 2 WAIT
        b_r = n_rise; b_d = n_done;
        pulse_start();
        wait_rises(b_r + 3, 200);
        k = 0;
        while (!e_busy[1] && k < 50) begin @(posedge clk); k++; end
        chk("flush_ti_busy_seen", 32'(e_busy[1]), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1;
        chk("flush_pulses", 32'(flushv), 32'b111);
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_step", 32'(step_o), 32'd0);
        chk("flush_buf", 32'(buf_sel_o), 32'd0);
        chk("flush_strobes", 32'(strobe), 32'd0);
        flush_i = 1'b0;
        @(posedge clk); #1;
        chk("flush_pulse_end", 32'(flushv), 32'b000);
        repeat (30) @(posedge clk);
        chk("flush_no_done", 32'(n_done - b_d), 32'd0);
        chk("flush_no_strobe", 32'(n_rise - b_r), 32'd3);
        b_r = n_rise; b_s = n_sd;
        pulse_start();
        wait_done(b_d + 1, 400);
        chk("reflush_rises", 32'(n_rise - b_r), 32'd5);
        chk("reflush_sd0", 32'(sd_step[b_s]), 32'd0);

        // start_i together with flush_i in IDLE
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        repeat (2) @(posedge clk);
        b_r = n_rise;
        @(negedge clk); start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        chk("sf_busy", 32'(busy_o), 32'd0);
        chk("sf_strobes", 32'(strobe), 32'd0);
        @(negedge clk); start_i = 1'b0; flush_i = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("sf_busy_later", 32'(busy_o), 32'd0);
        chk("sf_no_rise", 32'(n_rise - b_r), 32'd0);

        // Early busy on the ti engine
        mode[1] = 2'd1;
        b_r = n_rise; b_s = n_sd; b_d = n_done;
        pulse_start();
        wait_done(b_d + 1, 400);
        chk("early_width", 32'(width[b_r+1]), 32'd2);
        chk("early_latency", 32'(sd_cyc[b_s+1] - rise_cyc[b_r+1]), 32'd11);
        chk("early_sd_count", 32'(n_sd - b_s), 32'd5);
        mode[1] = 2'd0;

        // Asynchronous reset during step 1 START
        b_r = n_rise;
        pulse_start();
        wait_rises(b_r + 2, 100);
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", 32'({busy_o, done_o, error_o, step_o, step_done_o, buf_sel_o,
                             strobe, flushv}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_no_flush", 32'(flushv), 32'd0);
        chk("arst_idle", 32'(busy_o), 32'd0);

`ifdef BLOCK_LU_SCHED_WATCHDOG_EN
        // Watchdog: schur never goes busy
        mode[2] = 2'd2;
        b_r = n_rise; b_s = n_sd;
        pulse_start();
        k = 0;
        while (!error_o && k < 1000) begin @(posedge clk); k++; end
        chk("wd_error_seen", 32'(error_o), 32'd1);
        @(posedge clk); #1;
        chk("wd_timing", 32'(err_cyc - sd_cyc[b_s+2]), 32'd64);
        chk("wd_step", 32'(step_o), 32'd3);
        chk("wd_busy", 32'(busy_o), 32'd0);
        repeat (20) @(posedge clk); #1;
        chk("wd_error_hold", 32'(error_o), 32'd1);
        chk("wd_no_strobe", 32'(n_rise - b_r), 32'd4);
        pulse_start();
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        mode[2] = 2'd0;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
